// File: rtl/fp_iter_divider_if.sv
// Start/done handshake bundle for the iterative floating-point divider.
// The master issues operands; the slave returns the quotient and exception flags.
interface fp_iter_divider_if #(
  parameter int EXP_WIDTH      = 8,
  parameter int MANTISSA_WIDTH = 23
);
  localparam int W = 1 + EXP_WIDTH + MANTISSA_WIDTH;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         invalid;
  logic         div_by_zero;
  logic         overflow;
  logic         underflow;

  modport master (
    output start, a, b,
    input  busy, done, result, invalid, div_by_zero, overflow, underflow
  );

  modport slave (
    input  start, a, b,
    output busy, done, result, invalid, div_by_zero, overflow, underflow
  );
endinterface

// File: rtl/fp_iter_divider.sv
// Iterative IEEE-754 divider: restoring mantissa division, one quotient bit
// per cycle, round-to-nearest-even, denormals flushed to zero.
// Latency is fixed for all operands, special cases included.
module fp_iter_divider #(
  parameter int EXP_WIDTH      = 8,
  parameter int MANTISSA_WIDTH = 23
) (
  input  logic              clk,
  input  logic              reset,
  fp_iter_divider_if.slave  bus
);
  localparam int W    = 1 + EXP_WIDTH + MANTISSA_WIDTH;
  localparam int MW   = MANTISSA_WIDTH + 1;   // mantissa with hidden bit
  localparam int QW   = MANTISSA_WIDTH + 3;   // quotient: hidden, fraction, guard, extra
  localparam int EW   = EXP_WIDTH + 2;        // signed working exponent
  localparam int CW   = $clog2(QW);
  localparam int BIAS = 2 ** (EXP_WIDTH - 1) - 1;
  localparam int EMAX = 2 ** EXP_WIDTH - 1;

  localparam logic signed [EW-1:0] BIAS_S = EW'(BIAS);
  localparam logic signed [EW-1:0] EMAX_S = EW'(EMAX);
  localparam logic signed [EW-1:0] ONE_S  = EW'(1);
  localparam logic signed [EW-1:0] ZERO_S = '0;
  localparam logic [CW-1:0]        LAST_STEP = CW'(QW - 1);

  localparam logic [W-1:0] QNAN = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MANTISSA_WIDTH-1){1'b0}}};
  localparam logic [W-1:0] INF  = {1'b0, {EXP_WIDTH{1'b1}}, {MANTISSA_WIDTH{1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_DIVIDE, S_ROUND, S_DONE} state_t;

  state_t                 state_reg;
  logic [W-1:0]           a_reg, b_reg;
  logic                   sign_reg;
  logic signed [EW-1:0]   exp_reg;
  logic [MW-1:0]          mb_reg;
  logic [MW:0]            rem_reg;
  logic [QW-1:0]          quo_reg;
  logic [CW-1:0]          cnt_reg;
  logic                   zero_a_reg, zero_b_reg, inf_a_reg, inf_b_reg, nan_any_reg;
  logic                   busy_reg, done_reg;
  logic [W-1:0]           result_reg;
  logic                   invalid_reg, dbz_reg, ovf_reg, unf_reg;

  // Operand field views of the captured operands
  logic [EXP_WIDTH-1:0]      ea, eb;
  logic [MANTISSA_WIDTH-1:0] fa, fb;
  assign ea = a_reg[W-2:MANTISSA_WIDTH];
  assign eb = b_reg[W-2:MANTISSA_WIDTH];
  assign fa = a_reg[MANTISSA_WIDTH-1:0];
  assign fb = b_reg[MANTISSA_WIDTH-1:0];

  // One restoring-division step: subtract the divisor when it fits
  logic [MW:0] rem_next;
  logic        q_bit;
  always_comb begin
    rem_next = rem_reg;
    q_bit    = 1'b0;
    if (rem_reg >= {1'b0, mb_reg}) begin
      rem_next = rem_reg - {1'b0, mb_reg};
      q_bit    = 1'b1;
    end
  end

  // Normalise, round to nearest even, then apply range checks and special-case overrides
  logic [QW-1:0]             qn;
  logic signed [EW-1:0]      e_n;
  logic                      guard, sticky, round_up;
  logic [MW:0]               mant_r;
  logic [MANTISSA_WIDTH-1:0] frac_r;
  logic [W-1:0]              res_next;
  logic                      inv_next, dbz_next, ovf_next, unf_next;
  always_comb begin
    qn  = quo_reg;
    e_n = exp_reg;
    if (!quo_reg[QW-1]) begin
      qn  = quo_reg << 1;
      e_n = exp_reg - ONE_S;
    end
    guard    = qn[1];
    sticky   = qn[0] | (rem_reg != '0);
    round_up = guard & (sticky | qn[2]);
    mant_r   = {1'b0, qn[QW-1:2]} + {{MW{1'b0}}, round_up};
    frac_r   = mant_r[MANTISSA_WIDTH-1:0];
    if (mant_r[MW]) begin
      e_n    = e_n + ONE_S;
      frac_r = '0;
    end

    res_next = '0;
    inv_next = 1'b0;
    dbz_next = 1'b0;
    ovf_next = 1'b0;
    unf_next = 1'b0;
    if (nan_any_reg || (zero_a_reg && zero_b_reg) || (inf_a_reg && inf_b_reg)) begin
      res_next = QNAN;
      inv_next = 1'b1;
    end else if (inf_a_reg) begin
      res_next = INF | {sign_reg, {(W-1){1'b0}}};
    end else if (inf_b_reg || zero_a_reg) begin
      res_next = {sign_reg, {(W-1){1'b0}}};
    end else if (zero_b_reg) begin
      res_next = INF | {sign_reg, {(W-1){1'b0}}};
      dbz_next = 1'b1;
    end else if (e_n >= EMAX_S) begin
      res_next = INF | {sign_reg, {(W-1){1'b0}}};
      ovf_next = 1'b1;
    end else if (e_n <= ZERO_S) begin
      res_next = {sign_reg, {(W-1){1'b0}}};
      unf_next = 1'b1;
    end else begin
      res_next = {sign_reg, e_n[EXP_WIDTH-1:0], frac_r};
    end
  end

  // Control FSM with registered handshake outputs and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      sign_reg    <= 1'b0;
      exp_reg     <= '0;
      mb_reg      <= '0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      cnt_reg     <= '0;
      zero_a_reg  <= 1'b0;
      zero_b_reg  <= 1'b0;
      inf_a_reg   <= 1'b0;
      inf_b_reg   <= 1'b0;
      nan_any_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      result_reg  <= '0;
      invalid_reg <= 1'b0;
      dbz_reg     <= 1'b0;
      ovf_reg     <= 1'b0;
      unf_reg     <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (bus.start) begin
            a_reg     <= bus.a;
            b_reg     <= bus.b;
            busy_reg  <= 1'b1;
            state_reg <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          sign_reg    <= a_reg[W-1] ^ b_reg[W-1];
          exp_reg     <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS_S;
          rem_reg     <= {2'b01, fa};
          mb_reg      <= {1'b1, fb};
          quo_reg     <= '0;
          cnt_reg     <= '0;
          zero_a_reg  <= (ea == '0);
          zero_b_reg  <= (eb == '0);
          inf_a_reg   <= (ea == '1) && (fa == '0);
          inf_b_reg   <= (eb == '1) && (fb == '0);
          nan_any_reg <= ((ea == '1) && (fa != '0)) || ((eb == '1) && (fb != '0));
          state_reg   <= S_DIVIDE;
        end
        S_DIVIDE: begin
          rem_reg <= rem_next << 1;
          quo_reg <= {quo_reg[QW-2:0], q_bit};
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_STEP) state_reg <= S_ROUND;
        end
        S_ROUND: begin
          result_reg  <= res_next;
          invalid_reg <= inv_next;
          dbz_reg     <= dbz_next;
          ovf_reg     <= ovf_next;
          unf_reg     <= unf_next;
          done_reg    <= 1'b1;
          state_reg   <= S_DONE;
        end
        S_DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.result      = result_reg;
  assign bus.invalid     = invalid_reg;
  assign bus.div_by_zero = dbz_reg;
  assign bus.overflow    = ovf_reg;
  assign bus.underflow   = unf_reg;
endmodule

// File: tb/tb_fp_iter_divider.sv
// Directed bench for fp_iter_divider: hand-computed quotients, flags,
// fixed latency, ignored start while busy, and reset abort.
module tb_fp_iter_divider;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  fp_iter_divider_if #(.EXP_WIDTH(8), .MANTISSA_WIDTH(23)) bus ();

  fp_iter_divider #(.EXP_WIDTH(8), .MANTISSA_WIDTH(23)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // flags packed as {invalid, div_by_zero, overflow, underflow}
  task automatic run_op(input string name, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] exp_r, input logic [3:0] exp_f);
    int cyc;
    @(negedge clk);
    bus.a = av;
    bus.b = bv;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    check({name, "_busy"}, 64'(bus.busy), 64'd1);
    while (!bus.done && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_latency"}, 64'(cyc), 64'd29);
    check({name, "_result"}, 64'(bus.result), 64'(exp_r));
    check({name, "_flags"},
          64'({bus.invalid, bus.div_by_zero, bus.overflow, bus.underflow}), 64'(exp_f));
    @(negedge clk);
    check({name, "_done_pulse"}, 64'({bus.done, bus.busy}), 64'd0);
    $display("op %s: %h / %h -> %h flags %b latency %0d", name, av, bv, bus.result,
             {bus.invalid, bus.div_by_zero, bus.overflow, bus.underflow}, cyc);
  endtask

  initial begin
    int cyc;
    int dones;
    logic [31:0] seen_result;
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_outputs",
          64'({bus.busy, bus.done, bus.invalid, bus.div_by_zero, bus.overflow, bus.underflow}),
          64'd0);
    check("reset_result", 64'(bus.result), 64'd0);

    run_op("six_by_two",   32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000);
    run_op("one_third",    32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000);
    run_op("neg_third",    32'hBF800000, 32'h40400000, 32'hBEAAAAAB, 4'b0000);
    run_op("one_by_zero",  32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100);
    run_op("neg_by_zero",  32'hC0000000, 32'h00000000, 32'hFF800000, 4'b0100);
    run_op("zero_by_zero", 32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000);
    run_op("overflow",     32'h7F7FFFFF, 32'h3E800000, 32'h7F800000, 4'b0010);
    run_op("underflow",    32'h00800000, 32'h40000000, 32'h00000000, 4'b0001);
    run_op("inf_by_two",   32'h7F800000, 32'h40000000, 32'h7F800000, 4'b0000);
    run_op("two_by_inf",   32'h40000000, 32'h7F800000, 32'h00000000, 4'b0000);
    run_op("inf_by_inf",   32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b1000);
    run_op("nan_operand",  32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000);
    run_op("equal_ops",    32'h3F7FFFFF, 32'h3F7FFFFF, 32'h3F800000, 4'b0000);

    // start pulsed mid-operation with different operands must be ignored
    @(negedge clk);
    bus.a = 32'h40C00000;
    bus.b = 32'h40000000;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    dones = 0;
    seen_result = '0;
    while (cyc < 70) begin
      if (cyc == 5) begin
        bus.a = 32'h3F800000;
        bus.b = 32'h00000000;
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        dones++;
        seen_result = bus.result;
        check("busy_start_latency", 64'(cyc), 64'd29);
      end
      @(negedge clk);
      cyc++;
    end
    check("busy_start_done_count", 64'(dones), 64'd1);
    check("busy_start_result", 64'(seen_result), 64'h40400000);
    $display("op busy_start: dones %0d result %h", dones, seen_result);

    // reset at cycle 10 aborts the operation
    @(negedge clk);
    bus.a = 32'h3F800000;
    bus.b = 32'h40400000;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    while (cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy_done", 64'({bus.busy, bus.done}), 64'd0);
    check("abort_result", 64'(bus.result), 64'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) dones++;
      @(negedge clk);
    end
    check("abort_no_done", 64'(dones), 64'd0);
    $display("op reset_abort: dones after reset %0d", dones);

    run_op("after_reset", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
